// File: rtl/spm_pkg.sv
// Shared types and constants for the scratch-pad memory burst controller.
package spm_pkg;

  localparam int unsigned SpmAddrW   = 5;
  localparam int unsigned SpmDataW   = 8;
  localparam int unsigned SpmLenW    = 6;
  // Read-return buffer depth; two entries cover the 1-cycle memory latency at full rate.
  localparam int unsigned RdBufDepth = 2;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StRead,
    StDrain
  } spm_state_e;

endpackage

// File: rtl/spm_rd_fifo.sv
// Small synchronous FIFO with occupancy count; pushes when full and pops when empty
// are dropped.
module spm_rd_fifo
  import spm_pkg::*;
#(
  parameter int unsigned DataW   = SpmDataW,
  parameter int unsigned Depth   = RdBufDepth,
  localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW   = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [DataW-1:0] wdata,
  input  logic             pop,
  output logic [DataW-1:0] rdata,
  output logic [CntW-1:0]  count,
  output logic             full,
  output logic             empty
);

  logic [DataW-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Storage, pointers and occupancy; simultaneous push and pop keep the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/spm_burst_ctrl.sv
// Burst initiator for the single-port scratch-pad memory: write bursts from a
// valid/ready stream, read bursts returned on a valid/ready stream with backpressure.
module spm_burst_ctrl
  import spm_pkg::*;
#(
  parameter int unsigned ADDR_W = SpmAddrW,
  parameter int unsigned DATA_W = SpmDataW,
  parameter int unsigned LEN_W  = SpmLenW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wvalid,
  output logic              wready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  input  logic              rready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CntW = $clog2(RdBufDepth + 1);

  spm_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              out_q, out_d;   // one read issued, data not yet returned
  logic              done_q, done_d;

  logic              rd_issue, rd_pop, rd_push, rd_credit;
  logic [CntW-1:0]   fifo_count;
  logic              fifo_full, fifo_empty;
  logic [CntW:0]     occ;

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign wready    = (state_q == StWrite);
  assign rvalid    = ~fifo_empty;
  assign done      = done_q;
  assign rd_pop    = rvalid & rready;
  // Returns with no read in flight (e.g. one issued before a reset) are dropped.
  assign rd_push   = mem_rvalid & out_q & ~fifo_full;

  // Buffer slots committed to data held or in flight; a slot freed by this cycle's
  // pop is reusable at once, which sustains one beat per cycle.
  always_comb begin
    occ       = {1'b0, fifo_count} + {{CntW{1'b0}}, out_q} - {{CntW{1'b0}}, rd_pop};
    rd_credit = (occ < (CntW + 1)'(RdBufDepth));
  end

  spm_rd_fifo #(
    .DataW (DATA_W),
    .Depth (RdBufDepth)
  ) u_rd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_push),
    .wdata (mem_rdata),
    .pop   (rd_pop),
    .rdata (rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next state, address/length bookkeeping and memory-side strobes.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    done_d    = 1'b0;
    rd_issue  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          rem_d   = (cmd_len == '0) ? LEN_W'(1) : cmd_len;
          state_d = cmd_wr ? StWrite : StRead;
        end
      end
      StWrite: begin
        if (wvalid) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = addr_q;
          mem_wdata = wdata;
          addr_d    = addr_q + 1'b1;
          rem_d     = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      StRead: begin
        if (rd_credit) begin
          rd_issue = 1'b1;
          mem_en   = 1'b1;
          mem_addr = addr_q;
          addr_d   = addr_q + 1'b1;
          rem_d    = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (fifo_empty && !out_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // The memory always answers one cycle after a read is issued.
  assign out_d = rd_issue;

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      out_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

endmodule
